// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first, one bit per clock.
// Subtraction is compiled in only when SERIAL_ADD_SUB_SUB_EN is defined; otherwise op_sub is ignored.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cnt,
  output logic             ovf
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    bit_cnt;
  logic             carry;
  logic             bit_b;
  logic             bit_s;
  logic             carry_out;

`ifdef SERIAL_ADD_SUB_SUB_EN
  logic sub_q;
  assign bit_b = sh_b[0] ^ sub_q;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign bit_b         = sh_b[0];
`endif

  assign bit_s     = sh_a[0] ^ bit_b ^ carry;
  assign carry_out = (sh_a[0] & bit_b) | (sh_a[0] & carry) | (bit_b & carry);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      acc     <= '0;
      bit_cnt <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cnt     <= 1'b0;
      ovf     <= 1'b0;
`ifdef SERIAL_ADD_SUB_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sh_a    <= in_a;
            sh_b    <= in_b;
            acc     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
`ifdef SERIAL_ADD_SUB_SUB_EN
            sub_q   <= op_sub;
            carry   <= op_sub;
`else
            carry   <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          acc     <= {bit_s, acc[WIDTH-1:1]};
          sh_a    <= sh_a >> 1;
          sh_b    <= sh_b >> 1;
          carry   <= carry_out;
          bit_cnt <= bit_cnt + 1'b1;
          // On the MSB, 'carry' is the carry into the MSB, so ovf is carry-in xor carry-out.
          if (bit_cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= {bit_s, acc[WIDTH-1:1]};
            cnt   <= carry_out;
            ovf   <= carry ^ carry_out;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub (WIDTH=8): driver queues expected results, monitor checks done/busy/hold.
module tb_serial_add_sub;

  localparam int W = 8;
`ifdef SERIAL_ADD_SUB_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         busy, done, cnt, ovf;
  logic [W-1:0] sum;

  serial_add_sub #(.WIDTH(W)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .op_sub(op_sub),
    .in_a(in_a), .in_b(in_b), .busy(busy), .done(done),
    .sum(sum), .cnt(cnt), .ovf(ovf)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc    = 0;
  int          last_k = -100;
  logic [W+1:0] last  = '0;
  int          n_cmp  = 0;
  int          n_err  = 0;

  initial forever begin
    #5 clk = 1'b1; cyc++;
    #5 clk = 1'b0;
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] bb;
    logic [W:0]   t;
    exp_t         e;
    bb    = (s && SUB_EN) ? ~b : b;
    t     = {1'b0, a} + {1'b0, bb} + (W+1)'(s && SUB_EN);
    e.s   = t[W-1:0];
    e.c   = t[W];
    e.v   = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    e.cyc = 0;
    return e;
  endfunction

  // Waits for the predicted free slot (start held high with junk meanwhile), then issues one op.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
    exp_t x;
    @(negedge clk);
    while (!(cyc + 1 > last_k + W)) begin
      start = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); op_sub = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b1; in_a = a; in_b = b; op_sub = s;
    x = e; x.cyc = cyc + 1 + W;
    q.push_back(x);
    last_k = cyc + 1;
  endtask

  task automatic dvec(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [W-1:0] r, input logic c, input logic v);
    exp_t e;
    e.s = r; e.c = c; e.v = v; e.cyc = 0;
    issue(a, b, s, e);
  endtask

  task automatic drain();
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4 * W && q.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d results still outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: done pulses against the queue, outputs hold between dones, busy against the predicted window.
  initial forever begin
    exp_t e;
    logic exp_busy;
    @(posedge clk); #2;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      n_cmp++; n_err++;
      $display("FAIL missing_done: no done at cycle %0d, required one", q[0].cyc);
      void'(q.pop_front());
    end
    n_cmp++;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
      end else begin
        e = q.pop_front();
        if ({sum, cnt, ovf} !== {e.s, e.c, e.v} || cyc != e.cyc) begin
          n_err++;
          $display("FAIL result: sum=%h cnt=%b ovf=%b cyc=%0d, required sum=%h cnt=%b ovf=%b cyc=%0d",
                   sum, cnt, ovf, cyc, e.s, e.c, e.v, e.cyc);
        end
        last = {e.s, e.c, e.v};
      end
    end else if ({sum, cnt, ovf} !== last || done !== 1'b0) begin
      n_err++;
      $display("FAIL hold: done=%b {sum,cnt,ovf}=%h, required done=0 %h", done, {sum, cnt, ovf}, last);
    end
    exp_busy = (cyc >= last_k) && (cyc < last_k + W);
    n_cmp++;
    if (busy !== exp_busy) begin
      n_err++;
      $display("FAIL busy: busy=%b at cycle %0d, required %b", busy, cyc, exp_busy);
    end
  end

  initial begin
    #3;
    n_cmp++;
    if ({busy, done, sum, cnt, ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_state: %b, required all zero", {busy, done, sum, cnt, ovf});
    end
    #19 rst_n = 1'b1;

    dvec(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    drain();
    dvec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    dvec(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    dvec(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    dvec(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef SERIAL_ADD_SUB_SUB_EN
    dvec(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    dvec(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    dvec(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
    dvec(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
`else
    dvec(8'h05, 8'h07, 1'b1, 8'h0C, 1'b0, 1'b0);
    dvec(8'h80, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0);
`endif
    drain();

    // Start held high with fresh operands every cycle.
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a, b;
      logic         s;
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      issue(a, b, s, model(a, b, s));
    end
    drain();

    // Reset four cycles into an operation.
    dvec(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    drain();
    dvec(8'h55, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    last_k = -100;
    last   = '0;
    #1;
    n_cmp++;
    if ({busy, done, sum, cnt, ovf} !== '0) begin
      n_err++;
      $display("FAIL mid_op_reset: %b, required all zero", {busy, done, sum, cnt, ovf});
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    dvec(8'h3C, 8'h0A, 1'b0, 8'h46, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b;
      logic         s;
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      issue(a, b, s, model(a, b, s));
    end
    drain();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port sys_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to begin one operation; sampled only while busy=0.
REQ-005 SHALL have port op_sub  input  1  operation select, 0=add and 1=subtract; sampled with start.
REQ-006 SHALL have port in_a  input  WIDTH  first operand; sampled with start.
REQ-007 SHALL have port in_b  input  WIDTH  second operand; sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking that the result is valid.
REQ-010 SHALL have port sum  output  WIDTH  result of the last completed operation.
REQ-011 SHALL have port cnt  output  1  final carry out; for subtract, 1 = no borrow.
REQ-012 SHALL have port ovf  output  1  signed two's-complement overflow of the last operation.

Function
REQ-013 SHALL compute the result bit-serially, LSB first, one bit per clock, using a single 1-bit full-adder cell and a carry flip-flop.
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE: IDLE->SHIFT on start; SHIFT->DONE after WIDTH bit cycles; DONE->IDLE unconditionally, or DONE->SHIFT if start=1.
REQ-015 SHALL, when start is sampled at edge k, latch in_a, in_b and op_sub, clear the bit counter, and load the carry flip-flop with 0 (add) or 1 (subtract).
REQ-016 SHALL drive busy=1 for cycles k+1 through k+WIDTH and busy=0 otherwise.
REQ-017 SHALL drive done=1 for exactly cycle k+WIDTH+1; sum, cnt and ovf SHALL update in that same cycle.
REQ-018 SHALL hold sum, cnt and ovf stable from the done cycle until the next done cycle.
REQ-019 SHALL, for subtract, add in_a, bitwise-inverted in_b, and carry-in 1 (two's complement).
REQ-020 SHALL compute ovf as the carry into the MSB XOR the carry out of the MSB.
REQ-021 SHALL ignore start while busy=1, leaving the operation in flight and its latched operands unaffected.
REQ-022 SHALL accept start during the done cycle, giving back-to-back operations with one done pulse every WIDTH+1 cycles.
REQ-023 SHALL produce results modulo 2^WIDTH; no input value is illegal.

Reset
REQ-024 SHALL, on sys_rst_n=0 at any time including mid-operation, immediately enter IDLE, abort the operation, and never emit its done pulse.
REQ-025 SHALL reset busy=0, done=0, sum=0, cnt=0, ovf=0, the carry flip-flop, the bit counter and the operand shift registers to 0.
REQ-026 SHALL ignore start until the first rising edge of sys_clk after sys_rst_n deasserts.

Configuration
REQ-027 SHALL compile in subtraction only when macro SERIAL_ADD_SUB_SUB_EN is defined.
REQ-028 SHALL, without SERIAL_ADD_SUB_SUB_EN, ignore op_sub (port retained), always add with carry-in 0, and contain no inversion logic.

Verification (WIDTH=8)
REQ-029 SHALL cover add: start with in_a=8'h0F, in_b=8'h01, op_sub=0 -> busy for 8 cycles; done in cycle k+9 with sum=8'h10, cnt=0, ovf=0.
REQ-030 SHALL cover add wrap and overflow: 8'hFF+8'h01 -> sum=8'h00, cnt=1, ovf=0; then 8'h7F+8'h01 -> sum=8'h80, cnt=0, ovf=1.
REQ-031 SHALL cover subtract, with macro defined: 8'h05-8'h07 -> sum=8'hFE, cnt=0, ovf=0; 8'h80-8'h01 -> sum=8'h7F, cnt=1, ovf=1.
REQ-032 SHALL cover start held high continuously with new operands every cycle -> exactly one done pulse per 9 cycles; each result matches the operands sampled at its own start.
REQ-033 SHALL cover reset mid-operation: sys_rst_n low at cycle k+4 -> busy=0 immediately, no done pulse, all outputs 0; a new start after release completes normally.
REQ-034 SHALL cover a random self-check of 1000 operations against a behavioural model (in_a+in_b or in_a-in_b mod 256, with carry and overflow).
